// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl
//   Receive-side frame controller for the UART RX path. Keeps the external
//   edge counter cleared while idle. Oversamples RX_IN at mid-bit and
//   deserializes start, DATA_WIDTH data bits (LSB first), optional parity and
//   one stop bit. Each good byte is presented on P_DATA together with a
//   one-cycle data_valid strobe.
//
//   Optional feature macro: UART_RX_MAJORITY_EN
//     defined   : sampled bit = 2-of-3 majority of samples at Prescale/2-1,
//                 Prescale/2 and Prescale/2+1
//     undefined : sampled bit = single sample at Prescale/2
//
//   Ports
//     CLK, RST            oversampling clock, async active-low reset
//     RX_IN               serial line, idle high, already synchronized
//     Prescale            oversampling ratio (8 or 16), static during a frame
//     PAR_EN, PAR_TYP     parity present / odd(1) or even(0); latched at start
//     bit_counter         frame bit index from the edge counter
//     sample_counter      oversample index within the current bit
//     edge_conter_enable  1 holds the edge counter cleared
//     P_DATA, data_valid  last good byte and its one-cycle strobe
//     par_err, stp_err    error flags of the last frame
module uart_rx_frame_ctrl #(
  parameter int DATA_WIDTH     = 8,
  parameter int COUNTER_WIDTH  = 4,
  parameter int PRESCALE_WIDTH = 5
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      RX_IN,
  input  logic [PRESCALE_WIDTH-1:0] Prescale,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  input  logic [COUNTER_WIDTH-1:0]  bit_counter,
  input  logic [PRESCALE_WIDTH-1:0] sample_counter,
  output logic                      edge_conter_enable,
  output logic [DATA_WIDTH-1:0]     P_DATA,
  output logic                      data_valid,
  output logic                      par_err,
  output logic                      stp_err
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam logic [COUNTER_WIDTH-1:0]  LAST_DATA_BIT = COUNTER_WIDTH'(DATA_WIDTH);
  localparam logic [PRESCALE_WIDTH-1:0] ONE           = PRESCALE_WIDTH'(1);

  state_t                    state_q;
  logic [DATA_WIDTH-1:0]     shift_q;
  logic [DATA_WIDTH-1:0]     p_data_q;
  logic                      valid_q;
  logic                      par_err_q;
  logic                      stp_err_q;
  logic                      enable_q;
  logic                      par_en_q;
  logic                      par_typ_q;

  logic [PRESCALE_WIDTH-1:0] half_w;
  logic                      end_of_bit;
  logic                      samp_bit;
  logic                      samp_mid_q;

  assign half_w     = Prescale >> 1;
  assign end_of_bit = (sample_counter == (Prescale - ONE));

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      samp_mid_q <= 1'b1;
    end else if (sample_counter == half_w) begin
      samp_mid_q <= RX_IN;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic samp_early_q;
  logic samp_late_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      samp_early_q <= 1'b1;
      samp_late_q  <= 1'b1;
    end else begin
      if (sample_counter == (half_w - ONE)) samp_early_q <= RX_IN;
      if (sample_counter == (half_w + ONE)) samp_late_q  <= RX_IN;
    end
  end

  assign samp_bit = (samp_early_q & samp_mid_q) |
                    (samp_early_q & samp_late_q) |
                    (samp_mid_q   & samp_late_q);
`else
  assign samp_bit = samp_mid_q;
`endif

  // Enable is updated on the same edge as the state so that it is already low
  // during the first START cycle; the counter therefore presents
  // sample_counter=0 for that cycle and starts counting on the next edge.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      p_data_q  <= '0;
      valid_q   <= 1'b0;
      par_err_q <= 1'b0;
      stp_err_q <= 1'b0;
      enable_q  <= 1'b1;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          enable_q <= 1'b1;
          if (!RX_IN) begin
            state_q   <= START;
            enable_q  <= 1'b0;
            par_en_q  <= PAR_EN;
            par_typ_q <= PAR_TYP;
            par_err_q <= 1'b0;
            stp_err_q <= 1'b0;
          end
        end
        START: begin
          if (end_of_bit) begin
            if (samp_bit) begin
              state_q  <= IDLE;
              enable_q <= 1'b1;
            end else begin
              state_q <= DATA;
            end
          end
        end
        DATA: begin
          if (end_of_bit) begin
            shift_q <= {samp_bit, shift_q[DATA_WIDTH-1:1]};
            if (bit_counter == LAST_DATA_BIT) begin
              state_q <= par_en_q ? PARITY : STOP;
            end
          end
        end
        PARITY: begin
          if (end_of_bit) begin
            if ((^shift_q ^ par_typ_q) != samp_bit) par_err_q <= 1'b1;
            state_q <= STOP;
          end
        end
        STOP: begin
          if (end_of_bit) begin
            if (!samp_bit) begin
              stp_err_q <= 1'b1;
            end else if (!par_err_q) begin
              p_data_q <= shift_q;
              valid_q  <= 1'b1;
            end
            state_q  <= IDLE;
            enable_q <= 1'b1;
          end
        end
        default: begin
          state_q  <= IDLE;
          enable_q <= 1'b1;
        end
      endcase
    end
  end

  assign edge_conter_enable = enable_q;
  assign P_DATA             = p_data_q;
  assign data_valid         = valid_q;
  assign par_err            = par_err_q;
  assign stp_err            = stp_err_q;

endmodule
